pe_array_cfg_ctrl: RTL and testbench

PE_ARRAY_CFG_CTRL -- requirements
Module: pe_array_cfg_ctrl

---
 rtl/pe_cfg_pkg.sv | 25 ++
 rtl/pe_array_cfg_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_pe_array_cfg_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_cfg_pkg.sv
// Shared definitions for the PE array configuration controller.
//   - pe_cfg_state_e : controller state encoding
//   - INIT_MASK_W    : width of the init_mask field of a config word
//   - INST_LSB       : bit offset of the instruction field (init_mask sits above it)
//   - DEF_*          : default parameter widths
package pe_cfg_pkg;

    localparam int unsigned DEF_PE_INST_W = 32;
    localparam int unsigned DEF_ADDR_W    = 8;
    localparam int unsigned DEF_RUN_W     = 16;

    // Config word layout: {init_mask[INIT_MASK_W-1:0], inst[PE_INST_W-1:0]}
    localparam int unsigned INIT_MASK_W = 13;
    localparam int unsigned INST_LSB    = 0;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFetch = 3'd1,
        StWait  = 3'd2,
        StLoad  = 3'd3,
        StRun   = 3'd4,
        StDone  = 3'd5
    } pe_cfg_state_e;

endpackage

// File: rtl/pe_array_cfg_ctrl.sv
// PE array configuration controller.
// Streams cfg_len config words from a config memory starting at cfg_base into the PE
// array (3 cycles per word: FETCH, WAIT, LOAD), then holds run high for run_len cycles
// and pulses done. abort returns to IDLE from any state and clears the PE-facing outputs.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   start           one-cycle job request (accepted in IDLE only, abort wins)
//   abort           cancel current job
//   cfg_base        first config-word address (latched on start)
//   cfg_len         number of config words (latched on start)
//   run_len         run-phase length in cycles (latched on start)
//   cfg_rd          config-memory read strobe (FETCH)
//   cfg_addr        config-memory read address (base + index, wraps)
//   cfg_rdata       config word, valid the cycle after cfg_rd
//   init_PE_array   init strobes, non-zero only in LOAD
//   PE_config       instruction broadcast, held until reset or abort
//   run             PE array run enable
//   busy            high whenever not IDLE
//   done            one-cycle completion pulse
//   perf_cycles     non-IDLE cycle count of the current/last job
//                   (only with PE_ARRAY_CFG_CTRL_PERF_EN defined)
module pe_array_cfg_ctrl
    import pe_cfg_pkg::*;
#(
    parameter int unsigned PE_INST_W = DEF_PE_INST_W,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned RUN_W     = DEF_RUN_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             abort,
    input  logic [ADDR_W-1:0]                cfg_base,
    input  logic [ADDR_W-1:0]                cfg_len,
    input  logic [RUN_W-1:0]                 run_len,
    output logic                             cfg_rd,
    output logic [ADDR_W-1:0]                cfg_addr,
    input  logic [INIT_MASK_W+PE_INST_W-1:0] cfg_rdata,
    output logic [INIT_MASK_W-1:0]           init_PE_array,
    output logic [PE_INST_W-1:0]             PE_config,
    output logic                             run,
    output logic                             busy,
    output logic                             done
`ifdef PE_ARRAY_CFG_CTRL_PERF_EN
    ,
    output logic [31:0]                      perf_cycles
`endif
);

    pe_cfg_state_e          state_q;
    logic [ADDR_W-1:0]      base_q;
    logic [ADDR_W-1:0]      len_q;
    logic [RUN_W-1:0]       run_len_q;
    logic [ADDR_W-1:0]      idx_q;
    logic [RUN_W-1:0]       run_cnt_q;
    logic                   cfg_rd_q;
    logic [ADDR_W-1:0]      cfg_addr_q;
    logic [INIT_MASK_W-1:0] init_q;
    logic [PE_INST_W-1:0]   pe_cfg_q;
    logic                   run_q;
    logic                   done_q;

    logic [ADDR_W-1:0] idx_d;
    logic              more_words;

    always_comb begin
        idx_d = idx_q + ADDR_W'(1);
        // Extra bit so idx+1 cannot wrap when len is at its maximum.
        more_words = ({1'b0, idx_q} + (ADDR_W + 1)'(1)) < {1'b0, len_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            base_q     <= '0;
            len_q      <= '0;
            run_len_q  <= '0;
            idx_q      <= '0;
            run_cnt_q  <= '0;
            cfg_rd_q   <= 1'b0;
            cfg_addr_q <= '0;
            init_q     <= '0;
            pe_cfg_q   <= '0;
            run_q      <= 1'b0;
            done_q     <= 1'b0;
        end else if (abort && (state_q != StIdle)) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            run_cnt_q  <= '0;
            cfg_rd_q   <= 1'b0;
            cfg_addr_q <= '0;
            init_q     <= '0;
            pe_cfg_q   <= '0;
            run_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && !abort) begin
                        base_q    <= cfg_base;
                        len_q     <= cfg_len;
                        run_len_q <= run_len;
                        idx_q     <= '0;
                        if (cfg_len != '0) begin
                            state_q    <= StFetch;
                            cfg_rd_q   <= 1'b1;
                            cfg_addr_q <= cfg_base;
                        end else if (run_len != '0) begin
                            state_q   <= StRun;
                            run_q     <= 1'b1;
                            run_cnt_q <= run_len;
                        end else begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StFetch: begin
                    cfg_rd_q <= 1'b0;
                    state_q  <= StWait;
                end
                StWait: begin
                    init_q   <= cfg_rdata[PE_INST_W +: INIT_MASK_W];
                    pe_cfg_q <= cfg_rdata[INST_LSB +: PE_INST_W];
                    state_q  <= StLoad;
                end
                StLoad: begin
                    init_q <= '0;
                    idx_q  <= idx_d;
                    if (more_words) begin
                        state_q    <= StFetch;
                        cfg_rd_q   <= 1'b1;
                        cfg_addr_q <= base_q + idx_d;
                    end else if (run_len_q != '0) begin
                        state_q   <= StRun;
                        run_q     <= 1'b1;
                        run_cnt_q <= run_len_q;
                    end else begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StRun: begin
                    // run_cnt_q holds the cycles remaining including this one.
                    if (run_cnt_q == RUN_W'(1)) begin
                        run_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                    run_cnt_q <= run_cnt_q - RUN_W'(1);
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign cfg_rd        = cfg_rd_q;
    assign cfg_addr      = cfg_addr_q;
    assign init_PE_array = init_q;
    assign PE_config     = pe_cfg_q;
    assign run           = run_q;
    assign done          = done_q;
    assign busy          = (state_q != StIdle);

`ifdef PE_ARRAY_CFG_CTRL_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else if (state_q == StIdle) begin
            if (start && !abort) begin
                perf_q <= '0;
            end
        end else if (perf_q != '1) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_pe_array_cfg_ctrl.sv
// Self-checking bench for pe_array_cfg_ctrl: a cycle-indexed job model drives a
// per-cycle compare process, and literal expectations pin the directed scenarios.
module tb_pe_array_cfg_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  cfg_base = '0;
    logic [7:0]  cfg_len = '0;
    logic [15:0] run_len = '0;
    logic        cfg_rd;
    logic [7:0]  cfg_addr;
    logic [44:0] cfg_rdata = '0;
    logic [12:0] init_PE_array;
    logic [31:0] PE_config;
    logic        run;
    logic        busy;
    logic        done;
`ifdef PE_ARRAY_CFG_CTRL_PERF_EN
    logic [31:0] perf_cycles;
`endif

    pe_array_cfg_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .cfg_base      (cfg_base),
        .cfg_len       (cfg_len),
        .run_len       (run_len),
        .cfg_rd        (cfg_rd),
        .cfg_addr      (cfg_addr),
        .cfg_rdata     (cfg_rdata),
        .init_PE_array (init_PE_array),
        .PE_config     (PE_config),
        .run           (run),
        .busy          (busy),
        .done          (done)
`ifdef PE_ARRAY_CFG_CTRL_PERF_EN
        ,
        .perf_cycles   (perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Config memory: registered read, data valid the cycle after cfg_rd.
    logic [44:0] mem [256];
    always @(posedge clk) begin
        if (cfg_rd) cfg_rdata <= mem[cfg_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Job model: cycle k counts from the first cycle after start is sampled.
    bit          job_on = 1'b0;
    int          job_k;
    int          m_base, m_len, m_run, m_abort_k;
    logic [31:0] exp_pe = '0;

    // Observations of the DUT during a job, compared against literals afterwards.
    logic [7:0]  obs_addr [$];
    logic [12:0] obs_init [$];
    logic [31:0] obs_pe [$];
    int          obs_run_n, obs_done_n, obs_done_k;

    int          c_k, c_w;
    logic        e_rd, e_run, e_done, e_busy;
    logic [7:0]  e_addr;
    logic [12:0] e_init;
    logic [44:0] c_word;

    always @(negedge clk) begin
        e_rd = 1'b0; e_run = 1'b0; e_done = 1'b0; e_busy = 1'b0;
        e_addr = '0; e_init = '0; c_word = '0;
        if (job_on) begin
            c_k = job_k;
            job_k++;
            if (m_abort_k >= 0 && c_k > m_abort_k) begin
                job_on = 1'b0;
                exp_pe = '0;
            end else begin
                e_busy = 1'b1;
                if (c_k < 3 * m_len) begin
                    c_w    = c_k / 3;
                    c_word = mem[8'(m_base + c_w)];
                    if (c_k % 3 == 0) begin
                        e_rd   = 1'b1;
                        e_addr = 8'(m_base + c_w);
                    end else if (c_k % 3 == 2) begin
                        e_init = c_word[44:32];
                        exp_pe = c_word[31:0];
                    end
                end else if (c_k < 3 * m_len + m_run) begin
                    e_run = 1'b1;
                end else begin
                    e_done = 1'b1;
                    job_on = 1'b0;
                end
            end
            if (cfg_rd) obs_addr.push_back(cfg_addr);
            if (init_PE_array != '0) begin
                obs_init.push_back(init_PE_array);
                obs_pe.push_back(PE_config);
            end
            if (run) obs_run_n++;
            if (done) begin
                obs_done_n++;
                obs_done_k = c_k;
            end
        end
        check("cfg_rd", 64'(cfg_rd), 64'(e_rd));
        if (e_rd) check("cfg_addr", 64'(cfg_addr), 64'(e_addr));
        check("init_PE_array", 64'(init_PE_array), 64'(e_init));
        check("PE_config", 64'(PE_config), 64'(exp_pe));
        check("run", 64'(run), 64'(e_run));
        check("done", 64'(done), 64'(e_done));
        check("busy", 64'(busy), 64'(e_busy));
    end

    task automatic run_job(input int base, input int len, input int rl, input int abort_k,
                           input int glitch_k, input int rst_k);
        obs_addr.delete();
        obs_init.delete();
        obs_pe.delete();
        obs_run_n  = 0;
        obs_done_n = 0;
        obs_done_k = -1;
        @(posedge clk); #1;
        cfg_base = 8'(base);
        cfg_len  = 8'(len);
        run_len  = 16'(rl);
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble the job inputs so a design that does not latch them misbehaves.
        cfg_base  = 8'h5A;
        cfg_len   = 8'h07;
        run_len   = 16'h0099;
        m_base    = base;
        m_len     = len;
        m_run     = rl;
        m_abort_k = abort_k;
        job_k     = 0;
        job_on    = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (!job_on) break;
            start = (c == glitch_k);
            abort = (c == abort_k);
            if (c == rst_k) begin
                #6;
                rst    = 1'b1;
                job_on = 1'b0;
                exp_pe = '0;
                #1;
                check("rst_cfg_rd", 64'(cfg_rd), 64'd0);
                check("rst_cfg_addr", 64'(cfg_addr), 64'd0);
                check("rst_init", 64'(init_PE_array), 64'd0);
                check("rst_PE_config", 64'(PE_config), 64'd0);
                check("rst_run", 64'(run), 64'd0);
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_done", 64'(done), 64'd0);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        abort = 1'b0;
        if (job_on) begin
            checks++;
            errors++;
            $display("FAIL job_timeout: job still open after 200 cycles, expected completion");
            job_on = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = {13'h001F, 32'h0000_000A};
        mem[8'h11] = {13'h1E00, 32'h0000_000B};
        mem[8'h20] = {13'h1555, 32'h1234_5678};
        mem[8'h30] = {13'h0001, 32'h0000_C0DE};
        mem[8'hFF] = {13'h0100, 32'h0000_0011};
        mem[8'h00] = {13'h0002, 32'h0000_0022};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Two words then 4 run cycles: 11 cycles from FETCH to done inclusive.
        run_job(8'h10, 2, 4, -1, -1, -1);
        check("s1_nreads", 64'(obs_addr.size()), 64'd2);
        if (obs_addr.size() >= 2) begin
            check("s1_addr0", 64'(obs_addr[0]), 64'h10);
            check("s1_addr1", 64'(obs_addr[1]), 64'h11);
        end
        check("s1_nloads", 64'(obs_init.size()), 64'd2);
        if (obs_init.size() >= 2) begin
            check("s1_init0", 64'(obs_init[0]), 64'h001F);
            check("s1_pe0", 64'(obs_pe[0]), 64'hA);
            check("s1_init1", 64'(obs_init[1]), 64'h1E00);
            check("s1_pe1", 64'(obs_pe[1]), 64'hB);
        end
        check("s1_run_cycles", 64'(obs_run_n), 64'd4);
        check("s1_done_pulses", 64'(obs_done_n), 64'd1);
        check("s1_done_index", 64'(obs_done_k), 64'd10);
`ifdef PE_ARRAY_CFG_CTRL_PERF_EN
        check("s1_perf_cycles", 64'(perf_cycles), 64'd11);
`endif

        // No config words: straight to run.
        run_job(8'h40, 0, 3, -1, -1, -1);
        check("s2_nreads", 64'(obs_addr.size()), 64'd0);
        check("s2_run_cycles", 64'(obs_run_n), 64'd3);
        check("s2_done_index", 64'(obs_done_k), 64'd3);
        check("s2_done_pulses", 64'(obs_done_n), 64'd1);
`ifdef PE_ARRAY_CFG_CTRL_PERF_EN
        check("s2_perf_cycles", 64'(perf_cycles), 64'd4);
`endif

        // One word, no run phase; a stray start mid-job must be ignored.
        run_job(8'h20, 1, 0, -1, 1, -1);
        check("s3_nloads", 64'(obs_init.size()), 64'd1);
        if (obs_init.size() >= 1) begin
            check("s3_init0", 64'(obs_init[0]), 64'h1555);
            check("s3_pe0", 64'(obs_pe[0]), 64'h1234_5678);
        end
        check("s3_run_cycles", 64'(obs_run_n), 64'd0);
        check("s3_done_index", 64'(obs_done_k), 64'd3);

        // Abort during the second of five run cycles.
        run_job(8'h30, 1, 5, 4, -1, -1);
        check("s4_run_cycles", 64'(obs_run_n), 64'd2);
        check("s4_done_pulses", 64'(obs_done_n), 64'd0);

        // Address wrap, also proves a start after abort is accepted.
        run_job(8'hFF, 2, 1, -1, -1, -1);
        check("s5_nreads", 64'(obs_addr.size()), 64'd2);
        if (obs_addr.size() >= 2) begin
            check("s5_addr0", 64'(obs_addr[0]), 64'hFF);
            check("s5_addr1", 64'(obs_addr[1]), 64'h00);
        end
        check("s5_done_index", 64'(obs_done_k), 64'd7);

        // Reset asserted in the first LOAD cycle.
        run_job(8'h10, 2, 4, -1, -1, 2);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Recovery after reset.
        run_job(8'h40, 0, 1, -1, -1, -1);
        check("s7_run_cycles", 64'(obs_run_n), 64'd1);
        check("s7_done_index", 64'(obs_done_k), 64'd1);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
